lcd_write_scheduler: RTL and testbench
======================================

LCD_WRITE_SCHEDULER -- requirements
Module: lcd_write_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, SHALL set character buffer entries (power of two, 2..16).
REQ-002 Parameter LINE_LEN, default 16, SHALL set characters per LCD line.
REQ-003 Parameter ACK_TIMEOUT, default 255, SHALL set max cycles waiting for lcd_busy to rise after lcd_start.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 internal_reset  input  1  reset, synchronous, active-high.
REQ-006 scan_code  input  8  PS/2 scan code byte.
REQ-007 scan_valid  input  1  one-cycle strobe, scan_code valid.
REQ-008 lcd_busy  input  1  LCD driver busy executing a transfer.
REQ-009 lcd_data  output  8  byte to LCD driver (ASCII or command).
REQ-010 lcd_rs  output  1  1 = character data, 0 = command.
REQ-011 lcd_start  output  1  one-cycle request to LCD driver; lcd_data/lcd_rs stable while asserted and until lcd_busy falls.
REQ-012 overflow  output  1  sticky; a character was dropped on full buffer.
REQ-013 ack_error  output  1  sticky; ACK_TIMEOUT expired.

Function
REQ-014 Decoder SHALL treat 0xF0 as break prefix (set break flag) and 0xE0 as extended prefix (set ext flag); neither is enqueued.
REQ-015 A non-prefix code with break flag set and ext flag clear SHALL be translated and enqueued; both flags clear after any non-prefix code.
REQ-016 Make codes (no break flag) and extended codes SHALL be discarded; typematic repeats therefore never produce characters.
REQ-017 Translation SHALL map letters 0x1C..0x1A set to uppercase ASCII, digits to '0'..'9', 0x29 to 0x20, 0x5A (Enter) to internal token NEWLINE; unmapped codes dropped.
REQ-018 Enqueue SHALL occur the cycle after the terminating scan_valid (1-cycle latency).
REQ-019 Buffer full on enqueue: entry dropped, overflow set; simultaneous dequeue in same cycle frees space first and enqueue succeeds.
REQ-020 Writer FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, CURSOR_ISSUE, CURSOR_ACK, CURSOR_DONE.
REQ-021 IDLE: buffer non-empty and lcd_busy low -> pop entry, go ISSUE (NEWLINE -> CURSOR_ISSUE).
REQ-022 ISSUE: drive lcd_rs=1, lcd_data=char, lcd_start=1 for exactly one cycle -> WAIT_ACK.
REQ-023 WAIT_ACK: lcd_busy high -> WAIT_DONE; counter reaching ACK_TIMEOUT -> set ack_error, go IDLE, cursor not advanced.
REQ-024 WAIT_DONE: lcd_busy low -> advance column; column reaching LINE_LEN -> CURSOR_ISSUE, else IDLE.
REQ-025 Cursor advance on line end or NEWLINE: line toggles 0->1, 1->0 (wrap), column=0; command 0xC0 for line 1, 0x80 for line 0.
REQ-026 CURSOR_ISSUE/ACK/DONE SHALL mirror ISSUE/ACK/DONE with lcd_rs=0 and command byte, then go IDLE; timeout rules identical.
REQ-027 lcd_start SHALL never assert while lcd_busy is high.
REQ-028 Column counter width clog2(LINE_LEN+1); never exceeds LINE_LEN-1 in IDLE.

Reset
REQ-029 internal_reset SHALL, on the clock edge, clear FIFO, break/ext flags, column=0, line=0, state=IDLE, lcd_start=0, lcd_rs=0, lcd_data=0x00, overflow=0, ack_error=0.
REQ-030 Reset mid-transfer SHALL abandon the transfer; no lcd_start in the cycle after reset.
REQ-031 Reset SHALL take priority over every simultaneous event.

Structure
REQ-032 Package lcd_kbd_pkg SHALL hold scan-to-ASCII function, NEWLINE token, prefix constants 0xF0/0xE0, commands 0x80/0xC0, writer state enum.
REQ-033 Buffer SHALL be sub-module kbd_char_fifo (synchronous, full/empty flags, same-cycle push/pop).

Verification
REQ-034 F0,1C -> one lcd_start, lcd_rs=1, lcd_data=0x41; 1C alone -> no lcd_start.
REQ-035 E0,F0,75 -> nothing enqueued; F0,5A -> lcd_rs=0, lcd_data=0xC0, column=0.
REQ-036 17 released 'A' with LINE_LEN=16 -> 16 data writes, 0xC0 command, 17th 'A' written; 33rd write preceded by 0x80.
REQ-037 lcd_busy held high, 10 releases with FIFO_DEPTH=8 -> 8 stored, overflow=1, 8 writes after busy drops.
REQ-038 lcd_busy never rises after lcd_start -> ack_error=1 at cycle 255, FSM IDLE, next char issued.
REQ-039 internal_reset during WAIT_DONE -> all outputs reset values next cycle, FIFO empty, no lcd_start.

Source files
------------

// File: rtl/lcd_kbd_pkg.sv
// Shared constants, writer state encoding and PS/2 set-2 scan-code translation
// for the keyboard-to-LCD write path.
package lcd_kbd_pkg;

   localparam logic [7:0] SC_BREAK    = 8'hF0;
   localparam logic [7:0] SC_EXT      = 8'hE0;
   localparam logic [7:0] CMD_LINE0   = 8'h80;
   localparam logic [7:0] CMD_LINE1   = 8'hC0;
   // ASCII LF never comes out of the character map, so it is free to mark Enter.
   localparam logic [7:0] TOK_NEWLINE = 8'h0A;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_WAIT_DONE,
      ST_CURSOR_ISSUE,
      ST_CURSOR_ACK,
      ST_CURSOR_DONE
   } wr_state_e;

   typedef struct packed {
      logic       valid;
      logic [7:0] ch;
   } xlate_t;

   function automatic logic [7:0] cursor_cmd(input logic line);
      return line ? CMD_LINE1 : CMD_LINE0;
   endfunction

   function automatic xlate_t scan_to_ascii(input logic [7:0] sc);
      xlate_t r;
      r.valid = 1'b1;
      r.ch    = 8'h00;
      case (sc)
         8'h1C: r.ch = "A";
         8'h32: r.ch = "B";
         8'h21: r.ch = "C";
         8'h23: r.ch = "D";
         8'h24: r.ch = "E";
         8'h2B: r.ch = "F";
         8'h34: r.ch = "G";
         8'h33: r.ch = "H";
         8'h43: r.ch = "I";
         8'h3B: r.ch = "J";
         8'h42: r.ch = "K";
         8'h4B: r.ch = "L";
         8'h3A: r.ch = "M";
         8'h31: r.ch = "N";
         8'h44: r.ch = "O";
         8'h4D: r.ch = "P";
         8'h15: r.ch = "Q";
         8'h2D: r.ch = "R";
         8'h1B: r.ch = "S";
         8'h2C: r.ch = "T";
         8'h3C: r.ch = "U";
         8'h2A: r.ch = "V";
         8'h1D: r.ch = "W";
         8'h22: r.ch = "X";
         8'h35: r.ch = "Y";
         8'h1A: r.ch = "Z";
         8'h45: r.ch = "0";
         8'h16: r.ch = "1";
         8'h1E: r.ch = "2";
         8'h26: r.ch = "3";
         8'h25: r.ch = "4";
         8'h2E: r.ch = "5";
         8'h36: r.ch = "6";
         8'h3D: r.ch = "7";
         8'h3E: r.ch = "8";
         8'h46: r.ch = "9";
         8'h29: r.ch = 8'h20;
         8'h5A: r.ch = TOK_NEWLINE;
         default: r.valid = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/kbd_char_fifo.sv
// Synchronous character FIFO; a pop in the same cycle as a push on a full
// buffer frees the slot first so the push is accepted.
module kbd_char_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_do_pop;
   logic             w_do_push;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/lcd_write_scheduler.sv
// Decodes released PS/2 keys into characters, buffers them and writes them to
// an HD44780-style LCD driver with line wrapping and ack timeout.
module lcd_write_scheduler
   import lcd_kbd_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int LINE_LEN    = 16,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       internal_reset,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   input  logic       lcd_busy,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_start,
   output logic       overflow,
   output logic       ack_error
);

   localparam int COL_W = $clog2(LINE_LEN + 1);
   localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

   wr_state_e        r_state;
   wr_state_e        w_state_nxt;
   logic [7:0]       r_data;
   logic [7:0]       w_data_nxt;
   logic             r_rs;
   logic             w_rs_nxt;
   logic [COL_W-1:0] r_col;
   logic [COL_W-1:0] w_col_nxt;
   logic             r_line;
   logic             w_line_nxt;
   logic [ACK_W-1:0] r_ack_cnt;
   logic [ACK_W-1:0] w_ack_cnt_nxt;
   logic             r_ack_error;
   logic             w_ack_error_nxt;
   logic             r_overflow;
   logic             r_brk;
   logic             r_ext;

   xlate_t           w_xlate;
   logic             w_is_prefix;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [7:0]       w_head;

   // ---------------- scan-code decoder ----------------
   assign w_is_prefix = (scan_code == SC_BREAK) || (scan_code == SC_EXT);
   assign w_xlate     = scan_to_ascii(scan_code);
   assign w_push      = scan_valid && !w_is_prefix && r_brk && !r_ext && w_xlate.valid;

   always_ff @(posedge clk) begin
      if (internal_reset) begin
         r_brk <= 1'b0;
         r_ext <= 1'b0;
      end else if (scan_valid) begin
         if (scan_code == SC_BREAK) begin
            r_brk <= 1'b1;
         end else if (scan_code == SC_EXT) begin
            r_ext <= 1'b1;
         end else begin
            r_brk <= 1'b0;
            r_ext <= 1'b0;
         end
      end
   end

   kbd_char_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .i_rst   (internal_reset),
      .i_push  (w_push),
      .i_wdata (w_xlate.ch),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (internal_reset)                  r_overflow <= 1'b0;
      else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
   end

   // ---------------- writer FSM ----------------
   always_ff @(posedge clk) begin
      if (internal_reset) begin
         r_state     <= ST_IDLE;
         r_data      <= 8'h00;
         r_rs        <= 1'b0;
         r_col       <= '0;
         r_line      <= 1'b0;
         r_ack_cnt   <= '0;
         r_ack_error <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_data      <= w_data_nxt;
         r_rs        <= w_rs_nxt;
         r_col       <= w_col_nxt;
         r_line      <= w_line_nxt;
         r_ack_cnt   <= w_ack_cnt_nxt;
         r_ack_error <= w_ack_error_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      w_state_nxt     = r_state;
      w_data_nxt      = r_data;
      w_rs_nxt        = r_rs;
      w_col_nxt       = r_col;
      w_line_nxt      = r_line;
      w_ack_cnt_nxt   = r_ack_cnt;
      w_ack_error_nxt = r_ack_error;
      w_pop           = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (!w_empty && !lcd_busy) begin
               w_pop = 1'b1;
               if (w_head == TOK_NEWLINE) begin
                  w_line_nxt  = !r_line;
                  w_col_nxt   = '0;
                  w_rs_nxt    = 1'b0;
                  w_data_nxt  = cursor_cmd(!r_line);
                  w_state_nxt = ST_CURSOR_ISSUE;
               end else begin
                  w_rs_nxt    = 1'b1;
                  w_data_nxt  = w_head;
                  w_state_nxt = ST_ISSUE;
               end
            end
         end

         ST_ISSUE: begin
            w_ack_cnt_nxt = '0;
            w_state_nxt   = ST_WAIT_ACK;
         end

         ST_WAIT_ACK: begin
            if (lcd_busy) begin
               w_state_nxt = ST_WAIT_DONE;
            end else if (r_ack_cnt == ACK_LAST) begin
               w_ack_error_nxt = 1'b1;
               w_state_nxt     = ST_IDLE;
            end else begin
               w_ack_cnt_nxt = r_ack_cnt + 1'b1;
            end
         end

         ST_WAIT_DONE: begin
            if (!lcd_busy) begin
               if (r_col == COL_LAST) begin
                  // Line full: wrap to the other line before taking the next character.
                  w_line_nxt  = !r_line;
                  w_col_nxt   = '0;
                  w_rs_nxt    = 1'b0;
                  w_data_nxt  = cursor_cmd(!r_line);
                  w_state_nxt = ST_CURSOR_ISSUE;
               end else begin
                  w_col_nxt   = r_col + 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         end

         ST_CURSOR_ISSUE: begin
            w_ack_cnt_nxt = '0;
            w_state_nxt   = ST_CURSOR_ACK;
         end

         ST_CURSOR_ACK: begin
            if (lcd_busy) begin
               w_state_nxt = ST_CURSOR_DONE;
            end else if (r_ack_cnt == ACK_LAST) begin
               w_ack_error_nxt = 1'b1;
               w_state_nxt     = ST_IDLE;
            end else begin
               w_ack_cnt_nxt = r_ack_cnt + 1'b1;
            end
         end

         ST_CURSOR_DONE: begin
            if (!lcd_busy) w_state_nxt = ST_IDLE;
         end

         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign lcd_start = (r_state == ST_ISSUE) || (r_state == ST_CURSOR_ISSUE);
   assign lcd_data  = r_data;
   assign lcd_rs    = r_rs;
   assign overflow  = r_overflow;
   assign ack_error = r_ack_error;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Randomised and directed bench for lcd_write_scheduler: an LCD driver model
// answers lcd_start, and a queue of expected writes is built from key releases.
module tb_lcd_write_scheduler;

   localparam int DEPTH = 8;
   localparam int LLEN  = 16;
   localparam int ACK_T = 255;

   typedef enum int {DRV_NORMAL, DRV_HOLD, DRV_NOACK} drv_mode_e;

   logic       clk = 1'b0;
   logic       internal_reset = 1'b0;
   logic [7:0] scan_code = 8'h00;
   logic       scan_valid = 1'b0;
   logic       lcd_busy;
   logic [7:0] lcd_data;
   logic       lcd_rs;
   logic       lcd_start;
   logic       overflow;
   logic       ack_error;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_starts  = 0;
   int start_cyc = 0;

   drv_mode_e drv_mode = DRV_NORMAL;
   int  ack_max  = 3;
   int  busy_min = 1;
   int  busy_max = 6;
   bit  abort_req = 1'b0;

   logic [8:0] exp_q[$];
   bit m_line = 1'b0;
   int m_col  = 0;

   logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
      8'h3D, 8'h3E, 8'h46};
   logic [7:0] unmapped_sc [4] = '{8'h76, 8'h05, 8'h66, 8'h0D};
   logic [7:0] ext_sc [4] = '{8'h75, 8'h6B, 8'h74, 8'h72};

   lcd_write_scheduler #(
      .FIFO_DEPTH  (DEPTH),
      .LINE_LEN    (LLEN),
      .ACK_TIMEOUT (ACK_T)
   ) dut (
      .clk            (clk),
      .internal_reset (internal_reset),
      .scan_code      (scan_code),
      .scan_valid     (scan_valid),
      .lcd_busy       (lcd_busy),
      .lcd_data       (lcd_data),
      .lcd_rs         (lcd_rs),
      .lcd_start      (lcd_start),
      .overflow       (overflow),
      .ack_error      (ack_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int tb_xlate(input logic [7:0] c);
      for (int i = 0; i < 26; i++) if (letter_sc[i] == c) return 65 + i;
      for (int i = 0; i < 10; i++) if (digit_sc[i] == c) return 48 + i;
      if (c == 8'h29) return 32;
      if (c == 8'h5A) return -2;
      return -1;
   endfunction

   task automatic model_newline();
      m_line = !m_line;
      m_col  = 0;
      exp_q.push_back({1'b0, (m_line ? 8'hC0 : 8'h80)});
   endtask

   task automatic model_char(input int ascii);
      exp_q.push_back({1'b1, ascii[7:0]});
      m_col++;
      if (m_col == LLEN) model_newline();
   endtask

   task automatic model_key(input logic [7:0] c);
      int a;
      a = tb_xlate(c);
      if (a == -2)     model_newline();
      else if (a >= 0) model_char(a);
   endtask

   // ---------------- LCD driver model and write monitor ----------------
   initial begin
      logic [8:0] cap;
      int d;
      int len;
      lcd_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (drv_mode == DRV_HOLD) begin
            lcd_busy = 1'b1;
         end else if (drv_mode == DRV_NOACK) begin
            lcd_busy = 1'b0;
         end else begin
            lcd_busy = 1'b0;
            if (lcd_start) begin
               cap = {lcd_rs, lcd_data};
               d   = $urandom_range(1, ack_max);
               for (int i = 0; i < d && !abort_req; i++) @(negedge clk);
               lcd_busy = 1'b1;
               len = $urandom_range(busy_min, busy_max);
               for (int i = 0; i < len && !abort_req; i++) @(negedge clk);
               if (!abort_req) check("hold_while_busy", {lcd_rs, lcd_data}, cap);
               lcd_busy = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (lcd_start) begin
         n_starts++;
         start_cyc = cyc;
         check("start_vs_busy", lcd_busy, 0);
         if (exp_q.size() == 0) check("xfer_unexpected", {lcd_rs, lcd_data}, 9'h1FF);
         else                   check("xfer", {lcd_rs, lcd_data}, exp_q.pop_front());
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_code(input logic [7:0] c);
      @(negedge clk);
      scan_code  = c;
      scan_valid = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0;
   endtask

   task automatic key_release(input logic [7:0] c);
      send_code(8'hF0);
      send_code(c);
      model_key(c);
   endtask

   task automatic do_reset();
      @(negedge clk);
      internal_reset = 1'b1;
      repeat (2) @(negedge clk);
      internal_reset = 1'b0;
      exp_q.delete();
      m_line = 1'b0;
      m_col  = 0;
   endtask

   task automatic wait_room();
      for (int i = 0; i < 1000 && exp_q.size() > 3; i++) @(negedge clk);
   endtask

   task automatic drain(input string tag);
      int quiet;
      quiet = 0;
      for (int i = 0; i < 3000 && quiet < 8; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !lcd_busy) quiet++;
         else quiet = 0;
      end
      check(tag, exp_q.size(), 0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      int n0;
      int sc0;
      logic [7:0] c;
      int r;

      do_reset();
      check("rst_start", lcd_start, 0);
      check("rst_rs", lcd_rs, 0);
      check("rst_data", lcd_data, 8'h00);
      check("rst_overflow", overflow, 0);
      check("rst_ack_error", ack_error, 0);

      // A make code alone never produces a write.
      n0 = n_starts;
      send_code(8'h1C);
      repeat (20) @(negedge clk);
      check("make_only_no_write", n_starts - n0, 0);

      key_release(8'h1C);
      drain("drain_a");
      check("a_one_write", n_starts - n0, 1);

      // Extended release is ignored.
      n0 = n_starts;
      send_code(8'hE0);
      send_code(8'hF0);
      send_code(8'h75);
      repeat (20) @(negedge clk);
      check("ext_release_no_write", n_starts - n0, 0);

      key_release(8'h5A);
      drain("drain_enter");
      check("enter_one_write", n_starts - n0, 1);

      // 33 characters from a clean cursor: 0xC0 after 16, 0x80 after 32.
      do_reset();
      n0 = n_starts;
      for (int i = 0; i < 33; i++) begin
         wait_room();
         key_release(8'h1C);
      end
      drain("drain_wrap");
      check("wrap_write_count", n_starts - n0, 35);

      // Driver held busy: 8 of 10 characters fit, overflow flags on the 9th.
      drv_mode = DRV_HOLD;
      repeat (3) @(negedge clk);
      n0 = n_starts;
      for (int i = 0; i < 10; i++) begin
         send_code(8'hF0);
         send_code(letter_sc[1 + i]);
         if (i < DEPTH) model_char(66 + i);
         if (i == DEPTH - 1) begin
            @(negedge clk);
            check("ovf_clear_when_just_full", overflow, 0);
         end
      end
      @(negedge clk);
      check("ovf_set", overflow, 1);
      check("ovf_no_write_while_busy", n_starts - n0, 0);
      drv_mode = DRV_NORMAL;
      drain("drain_ovf");
      check("ovf_write_count", n_starts - n0, DEPTH);
      check("ovf_sticky", overflow, 1);

      // Driver never acknowledges: each write times out, cursor stays put.
      drv_mode = DRV_NOACK;
      n0 = n_starts;
      send_code(8'hF0);
      send_code(8'h1C);
      exp_q.push_back({1'b1, 8'h41});
      send_code(8'hF0);
      send_code(8'h32);
      exp_q.push_back({1'b1, 8'h42});
      for (int i = 0; i < 50 && n_starts == n0; i++) @(negedge clk);
      check("noack_first_start", n_starts - n0, 1);
      sc0 = start_cyc;
      while (cyc < sc0 + ACK_T) @(negedge clk);
      check("ack_error_not_early", ack_error, 0);
      @(negedge clk);
      check("ack_error_at_timeout", ack_error, 1);
      for (int i = 0; i < 20 && n_starts == n0 + 1; i++) @(negedge clk);
      check("next_char_after_timeout", n_starts - n0, 2);
      repeat (ACK_T + 10) @(negedge clk);
      drv_mode = DRV_NORMAL;
      for (int i = 0; i < 8; i++) key_release(letter_sc[i + 10]);
      drain("drain_after_timeout");

      // Reset while the driver is busy with a transfer.
      busy_min = 30;
      busy_max = 30;
      key_release(8'h21);
      key_release(8'h23);
      key_release(8'h24);
      for (int i = 0; i < 100 && !lcd_busy; i++) @(negedge clk);
      check("busy_seen_before_reset", lcd_busy, 1);
      repeat (3) @(negedge clk);
      n0 = n_starts;
      abort_req = 1'b1;
      internal_reset = 1'b1;
      @(negedge clk);
      internal_reset = 1'b0;
      check("midrst_start", lcd_start, 0);
      check("midrst_rs", lcd_rs, 0);
      check("midrst_data", lcd_data, 8'h00);
      check("midrst_overflow", overflow, 0);
      check("midrst_ack_error", ack_error, 0);
      exp_q.delete();
      m_line = 1'b0;
      m_col  = 0;
      repeat (40) @(negedge clk);
      check("midrst_fifo_empty", n_starts - n0, 0);
      abort_req = 1'b0;
      busy_min = 1;
      busy_max = 6;

      // Random keyboard traffic.
      for (int k = 0; k < 60; k++) begin
         wait_room();
         r = $urandom_range(0, 99);
         if (r < 60)      c = letter_sc[$urandom_range(0, 25)];
         else if (r < 75) c = digit_sc[$urandom_range(0, 9)];
         else if (r < 82) c = 8'h29;
         else if (r < 88) c = 8'h5A;
         else if (r < 94) c = unmapped_sc[$urandom_range(0, 3)];
         else             c = ext_sc[$urandom_range(0, 3)];
         if (r < 94) begin
            repeat ($urandom_range(1, 3)) send_code(c);
            key_release(c);
         end else begin
            send_code(8'hE0);
            send_code(c);
            send_code(8'hE0);
            send_code(8'hF0);
            send_code(c);
         end
      end
      drain("drain_random");
      check("random_no_overflow", overflow, 0);
      check("random_no_ack_error", ack_error, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
